// File: rtl/window_3x3_gen_pkg.sv
// Shared definitions for the 3x3 sliding-window generator.
// These cover the window geometry, the VGG16 per-layer frame sizes and the fill/stream state encoding.
package window_3x3_gen_pkg;

   localparam int WIN_SIZE = 3;

   // Square feature-map edge length at the input of each VGG16 conv block
   localparam int VGG_CONV1_DIM = 224;
   localparam int VGG_CONV2_DIM = 112;
   localparam int VGG_CONV3_DIM = 56;
   localparam int VGG_CONV4_DIM = 28;
   localparam int VGG_CONV5_DIM = 14;

   typedef enum logic {
      ST_FILL   = 1'b0,
      ST_STREAM = 1'b1
   } win_state_t;

endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// Single-port line store, one read and one write per beat at the same address.
// The read is combinational, so a beat sees the word as it was before its own write.
module window_3x3_gen_line_buffer #(
   parameter int DEPTH = 224,
   parameter int WIDTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             i_en,
   input  logic [AW-1:0]    i_addr,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   assign o_rdata = r_mem[i_addr];

   always_ff @(posedge clk) begin
      if (i_en) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 window generator: raster pixels in, one unpadded stride-1 window per beat out.
// Two previous rows are held in a packed line buffer. Counters and a fill/stream FSM gate emission.
module window_3x3_gen
   import window_3x3_gen_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = VGG_CONV1_DIM,
   parameter int IMG_HEIGHT = VGG_CONV1_DIM
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic                                       in_valid,
   input  logic [DATA_WIDTH-1:0]                      in_pixel,
   output logic                                       out_valid,
   output logic [WIN_SIZE*WIN_SIZE*DATA_WIDTH-1:0]    out_window,
   output logic [$clog2(IMG_HEIGHT)-1:0]              out_row,
   output logic [$clog2(IMG_WIDTH)-1:0]               out_col,
   output logic                                       frame_done
);

   localparam int NTAPS = WIN_SIZE * WIN_SIZE;
   localparam int CW    = $clog2(IMG_WIDTH);
   localparam int RW    = $clog2(IMG_HEIGHT);

   localparam logic [CW-1:0] COL_LAST      = CW'(IMG_WIDTH - 1);
   localparam logic [CW-1:0] COL_OFS       = CW'(WIN_SIZE - 1);
   localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_HEIGHT - 1);
   localparam logic [RW-1:0] ROW_OFS       = RW'(WIN_SIZE - 1);
   localparam logic [RW-1:0] ROW_FILL_LAST = RW'(WIN_SIZE - 2);

   logic [CW-1:0]              r_col;
   logic [RW-1:0]              r_row;
   win_state_t                 r_state;
   win_state_t                 w_state_nxt;
   logic                       w_last_col;
   logic                       w_last_row;
   logic                       w_emit;
   logic [2*DATA_WIDTH-1:0]    w_lb_rdata;
   logic [DATA_WIDTH-1:0]      w_lb1;
   logic [DATA_WIDTH-1:0]      w_lb0;
   logic [DATA_WIDTH-1:0]      r_win     [NTAPS];
   logic [DATA_WIDTH-1:0]      w_win_nxt [NTAPS];
   logic [NTAPS*DATA_WIDTH-1:0] w_win_flat;

   // Upper half of the word is the row two above the current one, lower half the row directly above
   window_3x3_gen_line_buffer #(
      .DEPTH (IMG_WIDTH),
      .WIDTH (2*DATA_WIDTH),
      .AW    (CW)
   ) u_line_buffer (
      .clk     (clk),
      .i_en    (in_valid),
      .i_addr  (r_col),
      .i_wdata ({w_lb0, in_pixel}),
      .o_rdata (w_lb_rdata)
   );

   assign w_lb1      = w_lb_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
   assign w_lb0      = w_lb_rdata[DATA_WIDTH-1:0];
   assign w_last_col = (r_col == COL_LAST);
   assign w_last_row = (r_row == ROW_LAST);

   always_comb begin
      for (int k = 0; k < NTAPS; k++) begin
         w_win_nxt[k] = r_win[k];
      end
      for (int r = 0; r < WIN_SIZE; r++) begin
         for (int c = 0; c < WIN_SIZE-1; c++) begin
            w_win_nxt[r*WIN_SIZE+c] = r_win[r*WIN_SIZE+c+1];
         end
      end
      w_win_nxt[WIN_SIZE-1]   = w_lb1;
      w_win_nxt[2*WIN_SIZE-1] = w_lb0;
      w_win_nxt[NTAPS-1]      = in_pixel;
   end

   always_comb begin
      w_win_flat = '0;
      for (int k = 0; k < NTAPS; k++) begin
         w_win_flat[k*DATA_WIDTH +: DATA_WIDTH] = w_win_nxt[k];
      end
   end

   always_ff @(posedge clk) begin
      if (in_valid) begin
         r_win <= w_win_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_col   <= '0;
         r_row   <= '0;
         r_state <= ST_FILL;
      end else begin
         r_state <= w_state_nxt;
         if (in_valid) begin
            r_col <= w_last_col ? '0 : r_col + 1'b1;
            if (w_last_col) begin
               r_row <= w_last_row ? '0 : r_row + 1'b1;
            end
         end
      end
   end

   // Columns 0/1 still hold the tail of the previous row, so emission waits for a full window
   always_comb begin
      w_state_nxt = r_state;
      w_emit      = 1'b0;
      if (r_state == ST_FILL) begin
         if (in_valid && w_last_col && (r_row == ROW_FILL_LAST)) begin
            w_state_nxt = ST_STREAM;
         end
      end else begin
         w_emit = in_valid && (r_col >= COL_OFS);
         if (in_valid && w_last_col && w_last_row) begin
            w_state_nxt = ST_FILL;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         out_window <= '0;
         out_row    <= '0;
         out_col    <= '0;
      end else begin
         out_valid  <= w_emit;
         frame_done <= w_emit && w_last_row && w_last_col;
         if (w_emit) begin
            out_window <= w_win_flat;
            out_row    <= r_row - ROW_OFS;
            out_col    <= r_col - COL_OFS;
         end
      end
   end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Scoreboard bench for window_3x3_gen: three instances (4x4, 5x3, 224x224) driven in parallel.
// An image-based reference model queues expected windows, and one monitor pops and compares them.
module tb_window_3x3_gen;

   typedef struct packed {
      logic [71:0] win;
      logic [15:0] row;
      logic [15:0] col;
      logic        fd;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
   logic        v_a = 1'b0, v_b = 1'b0, v_c = 1'b0;
   logic [7:0]  p_a = '0, p_b = '0, p_c = '0;
   logic        ov_a, ov_b, ov_c;
   logic        fd_a, fd_b, fd_c;
   logic [71:0] w_a, w_b, w_c;
   logic [1:0]  row_a, col_a;
   logic [1:0]  row_b;
   logic [2:0]  col_b;
   logic [7:0]  row_c, col_c;

   window_3x3_gen #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_dut_a (
      .clk(clk), .reset(rst_a), .in_valid(v_a), .in_pixel(p_a),
      .out_valid(ov_a), .out_window(w_a), .out_row(row_a), .out_col(col_a), .frame_done(fd_a));

   window_3x3_gen #(.DATA_WIDTH(8), .IMG_WIDTH(5), .IMG_HEIGHT(3)) u_dut_b (
      .clk(clk), .reset(rst_b), .in_valid(v_b), .in_pixel(p_b),
      .out_valid(ov_b), .out_window(w_b), .out_row(row_b), .out_col(col_b), .frame_done(fd_b));

   window_3x3_gen #(.DATA_WIDTH(8)) u_dut_c (
      .clk(clk), .reset(rst_c), .in_valid(v_c), .in_pixel(p_c),
      .out_valid(ov_c), .out_window(w_c), .out_row(row_c), .out_col(col_c), .frame_done(fd_c));

   exp_t       qa[$], qb[$], qc[$];
   logic [7:0] img [3][224][224];
   int         mr[3], mc[3], nfr[3], nfd[3];
   int         errors = 0;
   int         checks = 0;
   logic       vp_a = 1'b0, vp_b = 1'b0, vp_c = 1'b0;
   logic       rchk_done = 1'b0;
   logic       end_req = 1'b0;
   logic       end_done = 1'b0;

   function automatic int dim_w(int id);
      return (id == 0) ? 4 : (id == 1) ? 5 : 224;
   endfunction

   function automatic int dim_h(int id);
      return (id == 0) ? 4 : (id == 1) ? 3 : 224;
   endfunction

   task automatic model_beat(int id, logic [7:0] p);
      exp_t e;
      int r, c, w, h;
      w = dim_w(id);
      h = dim_h(id);
      r = mr[id];
      c = mc[id];
      img[id][r][c] = p;
      if (r >= 2 && c >= 2) begin
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               e.win[(3*i+j)*8 +: 8] = img[id][r-2+i][c-2+j];
         e.row = 16'(r - 2);
         e.col = 16'(c - 2);
         e.fd  = (r == h-1) && (c == w-1);
         if (e.fd) nfr[id]++;
         case (id)
            0:       qa.push_back(e);
            1:       qb.push_back(e);
            default: qc.push_back(e);
         endcase
      end
      if (c == w-1) begin
         mc[id] = 0;
         mr[id] = (r == h-1) ? 0 : r + 1;
      end else begin
         mc[id] = c + 1;
      end
   endtask

   task automatic drive(int id, logic v, logic [7:0] p);
      @(posedge clk);
      #1;
      case (id)
         0:       begin v_a = v; p_a = p; end
         1:       begin v_b = v; p_b = p; end
         default: begin v_c = v; p_c = p; end
      endcase
      if (v) model_beat(id, p);
   endtask

   task automatic chk(string nm, logic [71:0] act, logic [71:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   task automatic mon(int id, logic ov, logic fd, logic [71:0] w, int row, int col, logic vprev);
      exp_t e;
      string nm;
      nm = $sformatf("dut%0d", id);
      if (ov) begin
         chk({nm, " valid_after_beat"}, 72'(vprev), 72'(1));
         if (fd) nfd[id]++;
         if ((id == 0 && qa.size() == 0) || (id == 1 && qb.size() == 0) ||
             (id == 2 && qc.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected_window: got %h at (%0d,%0d) expected none", nm, w, row, col);
         end else begin
            case (id)
               0:       e = qa.pop_front();
               1:       e = qb.pop_front();
               default: e = qc.pop_front();
            endcase
            chk({nm, " window"}, w, e.win);
            chk({nm, " row"}, 72'(row), 72'(e.row));
            chk({nm, " col"}, 72'(col), 72'(e.col));
            chk({nm, " frame_done"}, 72'(fd), 72'(e.fd));
         end
      end else begin
         chk({nm, " frame_done_idle"}, 72'(fd), 72'(0));
      end
   endtask

   always @(negedge clk) begin
      if (!rchk_done) begin
         chk("reset_a valid", 72'(ov_a), 72'(0));
         chk("reset_a done",  72'(fd_a), 72'(0));
         chk("reset_a win",   w_a, 72'(0));
         chk("reset_a row",   72'(row_a), 72'(0));
         chk("reset_a col",   72'(col_a), 72'(0));
         chk("reset_b valid", 72'(ov_b), 72'(0));
         chk("reset_b win",   w_b, 72'(0));
         chk("reset_c valid", 72'(ov_c), 72'(0));
         chk("reset_c done",  72'(fd_c), 72'(0));
         chk("reset_c win",   w_c, 72'(0));
         rchk_done = 1'b1;
      end else begin
         mon(0, ov_a, fd_a, w_a, int'(row_a), int'(col_a), vp_a);
         mon(1, ov_b, fd_b, w_b, int'(row_b), int'(col_b), vp_b);
         mon(2, ov_c, fd_c, w_c, int'(row_c), int'(col_c), vp_c);
      end
      vp_a = v_a;
      vp_b = v_b;
      vp_c = v_c;
      if (end_req && !end_done) begin
         chk("dut0 leftover", 72'(qa.size()), 72'(0));
         chk("dut1 leftover", 72'(qb.size()), 72'(0));
         chk("dut2 leftover", 72'(qc.size()), 72'(0));
         chk("dut0 frame_done_count", 72'(nfd[0]), 72'(5));
         chk("dut1 frame_done_count", 72'(nfd[1]), 72'(1));
         chk("dut2 frame_done_count", 72'(nfd[2]), 72'(1));
         chk("dut0 model_frames", 72'(nfr[0]), 72'(5));
         end_done = 1'b1;
      end
   end

   task automatic seq_a();
      // contiguous frame
      for (int i = 0; i < 16; i++) drive(0, 1'b1, 8'(i));
      repeat (3) drive(0, 1'b0, 8'hEE);
      // same frame with random gaps and junk pixels on idle cycles
      for (int i = 0; i < 16; i++) begin
         repeat ($urandom_range(0, 5)) drive(0, 1'b0, 8'($urandom));
         drive(0, 1'b1, 8'(i));
      end
      repeat (2) drive(0, 1'b0, 8'h55);
      // back-to-back frames
      for (int i = 0; i < 16; i++) drive(0, 1'b1, 8'(i));
      for (int i = 0; i < 16; i++) drive(0, 1'b1, 8'(100 + i));
      repeat (2) drive(0, 1'b0, 8'h00);
      // reset mid-frame after pixel 9
      for (int i = 0; i < 10; i++) drive(0, 1'b1, 8'(i));
      @(posedge clk);
      #1;
      rst_a = 1'b1;
      v_a   = 1'b1;
      p_a   = 8'hAA;
      @(posedge clk);
      #1;
      rst_a = 1'b0;
      v_a   = 1'b0;
      mr[0] = 0;
      mc[0] = 0;
      for (int i = 0; i < 16; i++) drive(0, 1'b1, 8'(i));
      drive(0, 1'b0, 8'h00);
   endtask

   task automatic seq_b();
      for (int i = 0; i < 15; i++) drive(1, 1'b1, 8'(200 + i));
      drive(1, 1'b0, 8'h00);
   endtask

   task automatic seq_c();
      for (int i = 0; i < 224*224; i++) drive(2, 1'b1, 8'($urandom));
      drive(2, 1'b0, 8'h00);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         mr[i] = 0; mc[i] = 0; nfr[i] = 0; nfd[i] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst_a = 1'b0;
      rst_b = 1'b0;
      rst_c = 1'b0;
      fork
         seq_a();
         seq_b();
         seq_c();
      join
      repeat (4) @(posedge clk);
      #1;
      end_req = 1'b1;
      repeat (2) @(posedge clk);
      if (!end_done) begin
         errors++;
         $display("FAIL end_check: got not_done expected done");
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
